// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 2:1 data mux: grants one requester lane at a time,
// drives the mux select and registers the chosen lane onto a valid/ready output.
module mux_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] data_in,
    input  logic               out_ready,
    output logic [1:0]         grant,
    output logic               sel,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid_out,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             sel_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic             space;
    logic             accept;
    logic             cur_lane;
    logic             other_lane;
    logic             leave;
    logic [WIDTH-1:0] lane_data;

    // Handshake: requester i transfers when grant[i] & req[i]; downstream consumes
    // data_out when valid_out & out_ready. The output slot is free when empty or draining.
    assign space      = !valid_q || out_ready;
    assign grant[0]   = (state_q == GRANT0) && space;
    assign grant[1]   = (state_q == GRANT1) && space;
    assign accept     = |(req & grant);
    assign cur_lane   = (state_q == GRANT1);
    assign other_lane = !cur_lane;
    assign cnt_d      = cnt_q + CW'(accept);
    assign leave      = !req[cur_lane] || (cnt_d == CW'(HOLD_MAX));
    assign lane_data  = cur_lane ? data_in[WIDTH +: WIDTH] : data_in[0 +: WIDTH];

    assign sel       = sel_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (req)
                        2'b01: begin
                            state_q <= GRANT0;
                            sel_q   <= 1'b0;
                        end
                        2'b10: begin
                            state_q <= GRANT1;
                            sel_q   <= 1'b1;
                        end
                        2'b11: begin
                            state_q <= last_q ? GRANT0 : GRANT1;
                            sel_q   <= !last_q;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
                GRANT0, GRANT1: begin
                    if (leave) begin
                        last_q <= cur_lane;
                        cnt_q  <= '0;
                        // Switch is decided alongside the final accept, so no bubble.
                        if (req[other_lane]) begin
                            state_q <= other_lane ? GRANT1 : GRANT0;
                            sel_q   <= other_lane;
                        end else if (req[cur_lane]) begin
                            state_q <= state_q;
                            sel_q   <= cur_lane;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= lane_data;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule
